// File: rtl/hs_rr_arbiter_if.sv
// Handshake bundle between four beat requesters, the arbiter and one downstream sink.
// The slave modport is the arbiter side; the master modport is the requesters plus the sink.
interface hs_rr_arbiter_if #(
   parameter int WIDTH = 9
);
   logic [3:0]         s_vaild;
   logic [4*WIDTH-1:0] s_data;
   logic [3:0]         s_ready;
   logic               m_vaild;
   logic [WIDTH-1:0]   m_data;
   logic               m_ready;
   logic [3:0]         grant;
   logic               busy;

   modport slave (
      input  s_vaild, s_data, m_ready,
      output s_ready, m_vaild, m_data, grant, busy
   );

   modport master (
      output s_vaild, s_data, m_ready,
      input  s_ready, m_vaild, m_data, grant, busy
   );
endinterface

// File: rtl/hs_rr_arbiter.sv
// Four-way round-robin burst arbiter merging valid/ready beat streams onto one output.
// Macro ARB_SKID_EN selects a registered 2-entry skid output stage instead of the combinational pass-through.
module hs_rr_arbiter #(
   parameter int WIDTH = 9,
   parameter int BURST = 16
) (
   input logic            clk,
   input logic            s_rst,
   hs_rr_arbiter_if.slave bus
);
   typedef enum logic {IDLE, LOCK} state_t;

   localparam logic [7:0] LAST = 8'(BURST - 1);

   state_t           state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [1:0]       owner, owner_nxt;
   logic [7:0]       count, count_nxt;
   logic             owner_vld;
   logic             owner_rdy;
   logic             owner_xfer;
   logic [WIDTH-1:0] owner_data;

   // First requesting index at or after start, wrapping mod 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
      logic [1:0] pick;
      logic [1:0] cand;
      pick = start;
      for (int k = 3; k >= 0; k--) begin
         cand = start + 2'(k);
         if (req[cand]) pick = cand;
      end
      return pick;
   endfunction

   always_comb begin
      owner_vld  = bus.s_vaild[owner];
      owner_data = bus.s_data[int'(owner)*WIDTH +: WIDTH];
      owner_xfer = (state == LOCK) && owner_vld && owner_rdy;
      bus.grant  = (state == LOCK) ? (4'b0001 << owner) : 4'b0000;
      bus.s_ready = bus.grant & {4{owner_rdy}};
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (|bus.s_vaild) begin
               state_nxt = LOCK;
               owner_nxt = rr_pick(bus.s_vaild, ptr);
               count_nxt = '0;
            end
         end
         LOCK: begin
            if (owner_xfer) count_nxt = count + 8'd1;
            // Release always lands in IDLE, so a new owner is chosen one cycle later.
            if (!owner_vld || (owner_xfer && count == LAST)) begin
               state_nxt = IDLE;
               ptr_nxt   = owner + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge s_rst) begin
      if (!s_rst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         count <= count_nxt;
      end
   end

`ifdef ARB_SKID_EN
   logic             out_vld_p1;
   logic [WIDTH-1:0] out_data_p1;
   logic             skid_vld_p0;
   logic [WIDTH-1:0] skid_data_p0;

   // Ready is a pure flop output: the skid slot absorbs the beat accepted while the output stalls.
   assign owner_rdy = !skid_vld_p0;

   // ---- p0 (skid slot) -> p1 (output register) ----
   always_ff @(posedge clk or negedge s_rst) begin
      if (!s_rst) begin
         out_vld_p1   <= 1'b0;
         out_data_p1  <= '0;
         skid_vld_p0  <= 1'b0;
         skid_data_p0 <= '0;
      end else if (!out_vld_p1 || bus.m_ready) begin
         if (skid_vld_p0) begin
            out_vld_p1  <= 1'b1;
            out_data_p1 <= skid_data_p0;
            skid_vld_p0 <= 1'b0;
         end else begin
            out_vld_p1 <= owner_xfer;
            if (owner_xfer) out_data_p1 <= owner_data;
         end
      end else if (owner_xfer) begin
         skid_vld_p0  <= 1'b1;
         skid_data_p0 <= owner_data;
      end
   end

   always_comb begin
      bus.m_vaild = out_vld_p1;
      bus.m_data  = out_data_p1;
      bus.busy    = (state == LOCK) || out_vld_p1 || skid_vld_p0;
   end
`else
   assign owner_rdy = bus.m_ready;

   always_comb begin
      bus.m_vaild = (state == LOCK) && owner_vld;
      bus.m_data  = (state == LOCK) ? owner_data : '0;
      bus.busy    = (state == LOCK);
   end
`endif
endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 9, data width per beat.
REQ-002 Parameter BURST, default 16, max beats per grant (2..256).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 s_rst  input  1  reset, asynchronous assert, active-low, synchronous deassert handled externally.
REQ-005 s_vaild  input  4  per-requester beat valid; bit i = requester i.
REQ-006 s_data  input  4*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-007 s_ready  output  4  per-requester accept; beat transfers when s_vaild[i] & s_ready[i].
REQ-008 m_vaild  output  1  shared downstream beat valid.
REQ-009 m_data  output  WIDTH  shared downstream data.
REQ-010 m_ready  input  1  downstream accept; transfer when m_vaild & m_ready.
REQ-011 grant  output  4  one-hot current owner, 0 when IDLE.
REQ-012 busy  output  1  high when state is LOCK or output stage holds data.

Function
REQ-013 FSM states IDLE, LOCK only.
REQ-014 IDLE: if any s_vaild bit set, select first set bit scanning ptr, ptr+1, ... mod 4; next cycle state=LOCK, grant=that bit, beat count=0.
REQ-015 IDLE: s_ready=0 for all requesters; no upstream beat accepted.
REQ-016 LOCK: only s_ready[owner] may be high; all other s_ready bits 0.
REQ-017 LOCK: each upstream transfer from owner increments beat count by 1 (8-bit counter, no wrap within a grant).
REQ-018 LOCK -> IDLE when owner transfers beat with count==BURST-1, or when s_vaild[owner]==0 in LOCK; ptr <= owner+1 mod 4 on release.
REQ-019 Release on BURST and new request evaluation never occur in same cycle: exactly one IDLE cycle between grants.
REQ-020 Simultaneous requests: round-robin order guaranteed; requester waits at most 3 grants.
REQ-021 Data of a beat delivered unmodified, in accept order; no beat dropped or duplicated.
REQ-022 m_vaild, once high, held with stable m_data until m_ready (when ARB_SKID_EN defined); pass-through mode inherits source stability.
REQ-023 Owner deasserting s_vaild mid-grant releases grant; no partial beat exists.

Reset
REQ-024 s_rst low asynchronously forces: state=IDLE, ptr=0, count=0, grant=0, s_ready=0, m_vaild=0, busy=0, skid buffer empty, m_data=0.
REQ-025 Reset mid-grant discards buffered beats; first post-reset arbitration starts from requester 0.

Configuration
REQ-026 Macro ARB_SKID_EN selects output stage.
REQ-027 With ARB_SKID_EN: 2-entry registered skid buffer; m_vaild/m_data registered; latency 1 cycle upstream accept -> m_vaild; s_ready[owner] = buffer has free entry (registered); full throughput 1 beat/cycle under m_ready=1; busy includes buffer non-empty.
REQ-028 Without ARB_SKID_EN: combinational pass-through in LOCK: m_vaild=s_vaild[owner], m_data=s_data[owner], s_ready[owner]=m_ready; latency 0; m_vaild=0 and m_data=0 in IDLE.

Verification
REQ-029 Single requester 0, s_vaild held high, m_ready=1, BURST=16 -> 16 beats granted, 1 IDLE cycle, re-grant to requester 0; data order preserved.
REQ-030 All 4 requesters valid continuously -> grant sequence 0,1,2,3,0 each 16 beats, one idle cycle between grants.
REQ-031 Requester 2 drops s_vaild after 5 beats -> grant released next cycle, ptr=3, requester 3 granted if requesting.
REQ-032 m_ready toggled per random pattern (toggle period 20-300 ns) with ARB_SKID_EN -> no loss/duplication, m_data stable while m_vaild & !m_ready.
REQ-033 s_rst pulsed low mid-burst (beat 7 of requester 1) -> all outputs 0 immediately, after release requester 0 granted first.
REQ-034 Build without ARB_SKID_EN, same stimulus as REQ-029 -> m_vaild same cycle as s_vaild[owner], zero-latency data match.
